// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: N requesters share one resource with a rotating
// priority pointer, bounded hold time under contention, and a dead cycle between owners.
module rr_grant_scheduler #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    gnt_valid,
  output logic                    preempt
);

  localparam int          IDW = $clog2(NREQ);
  localparam int          HW  = $clog2(MAX_HOLD) + 1;
  localparam int unsigned N   = NREQ;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             preempt_q, preempt_d;

  logic             found;
  logic [IDW-1:0]   pick;
  int unsigned      idx;

  // Rotating scan starting at ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx[IDW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end
  end

  // Outputs decode only from registered state and owner.
  always_comb begin
    gnt = '0;
    if (state_q == GNT) gnt[owner_q] = 1'b1;
  end

  assign gnt_valid = (state_q == GNT);
  assign gnt_id    = gnt_valid ? owner_q : '0;
  assign preempt   = (state_q == RELEASE) && preempt_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        if (found) begin
          state_d = GNT;
          owner_d = pick;
          hold_d  = HW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GNT: begin
        if (!req[owner_q] ||
            ((hold_q == HW'(MAX_HOLD)) && ((req & ~gnt) != '0))) begin
          state_d   = RELEASE;
          preempt_d = req[owner_q];
          ptr_d     = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Scoreboard bench for rr_grant_scheduler: a cycle-level ownership model predicts
// each post-edge output; a monitor pops and compares one entry per clock.
module tb_rr_grant_scheduler;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req   = '0;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_id;
  logic            gnt_valid;
  logic            preempt;

  rr_grant_scheduler #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NREQ-1:0] gnt;
    int              id;
    logic            valid;
    logic            pre;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: who owns the resource, for how many cycles, and where the scan starts.
  int m_owner = -1;
  int m_run   = 0;
  int m_ptr   = 0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_run   = 0;
    m_ptr   = 0;
  endtask

  // Advance the model by one clock edge with the given request vector.
  task automatic step_push(input logic [NREQ-1:0] r);
    exp_t e;
    bit   pre = 1'b0;
    if (m_owner >= 0) begin
      logic [NREQ-1:0] others = r & ~(NREQ'(1) << m_owner);
      if (!r[m_owner] || (m_run >= MAX_HOLD && others != '0)) begin
        pre     = r[m_owner];
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end else begin
        m_run++;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        int j = (m_ptr + i) % NREQ;
        if (m_owner < 0 && r[j]) begin
          m_owner = j;
          m_run   = 1;
        end
      end
    end
    e.gnt   = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    e.id    = (m_owner >= 0) ? m_owner : 0;
    e.valid = (m_owner >= 0);
    e.pre   = pre;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [NREQ-1:0] r);
    @(negedge clock);
    req = r;
    step_push(r);
  endtask

  // Monitor: one expected entry per edge; also checks the inter-owner gap.
  logic [NREQ-1:0] prev_gnt = '0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt", int'(gnt), int'(e.gnt));
        check("gnt_valid", int'(gnt_valid), int'(e.valid));
        check("preempt", int'(preempt), int'(e.pre));
        if (e.valid) check("gnt_id", int'(gnt_id), e.id);
        if (prev_gnt != '0 && gnt != '0 && gnt != prev_gnt) begin
          n_cmp++;
          n_bad++;
          $display("FAIL gap: owner %b followed %b directly at %0t", gnt, prev_gnt, $time);
        end
        prev_gnt = gnt;
      end
    end
  end

  initial begin
    logic [NREQ-1:0] r;
    #2;
    check("reset_gnt", int'(gnt), 0);
    check("reset_valid", int'(gnt_valid), 0);
    check("reset_preempt", int'(preempt), 0);
    check("reset_id", int'(gnt_id), 0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    step_push('0);

    // Async reset mid-grant
    repeat (3) drive(4'b0010);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async_gnt", int'(gnt), 0);
    check("async_valid", int'(gnt_valid), 0);
    check("async_preempt", int'(preempt), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    req   = '0;
    model_reset();
    step_push('0);
    repeat (2) drive('0);

    // Single requester held, then dropped
    repeat (12) drive(4'b0001);
    repeat (3) drive(4'b0000);

    // Simultaneous requests; requester 0 drops after two grant cycles
    drive(4'b1000);
    drive(4'b0000);
    drive(4'b0000);
    repeat (2) drive(4'b0101);
    repeat (4) drive(4'b0100);
    repeat (2) drive(4'b0000);

    // Constant contention forces preemption
    repeat (24) drive(4'b0011);
    repeat (2) drive(4'b0000);

    // Pointer wrap
    repeat (2) drive(4'b1000);
    drive(4'b0000);
    repeat (3) drive(4'b1001);
    drive(4'b1000);
    repeat (3) drive(4'b1001);
    repeat (2) drive(4'b0000);

    // Request drops during the dead cycle
    repeat (2) drive(4'b0001);
    drive(4'b0011);
    drive(4'b0010);
    drive(4'b0000);
    repeat (2) drive(4'b0000);

    // Random sticky requests so owners persist and preemption occurs
    r = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      drive(r);
    end
    drive('0);

    @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
Round-robin grant scheduler that shares one downstream resource among NREQ requesters. It generalises the team's two-requester grant FSM to N requesters and adds fairness: a rotating priority pointer, a bounded hold time with preemption, and a one-cycle dead cycle between owners. It sits between request sources and the shared datapath, driving a registered one-hot grant.

Parameters:
NREQ, 4, number of requesters (2..8)
MAX_HOLD, 4, max consecutive grant cycles for one owner while another requester is waiting (>=1)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
req  input  NREQ  per-requester request level; held high while it needs the resource
gnt  output  NREQ  registered one-hot grant; all zero when nobody owns the resource
gnt_id  output  clog2(NREQ)  index of current owner; valid only when gnt_valid=1
gnt_valid  output  1  high while any gnt bit is set
preempt  output  1  one-cycle pulse in the dead cycle after a forced release

Behaviour:
- Reset (reset=0, asynchronous), effective immediately with no clock edge:
  - state=IDLE, ptr=0, hold_cnt=0
  - gnt=0, gnt_id=0, gnt_valid=0, preempt=0
  - Reset mid-grant drops gnt in the same cycle.
- All outputs are registered and decoded from state and owner only; nothing is combinational from req.
- States: IDLE, GNT, RELEASE.
- Arbitration (IDLE and RELEASE only):
  - Pick the first set req bit scanning ptr, ptr+1, … NREQ-1, 0, … ptr-1 (modulo NREQ).
  - If found: move to GNT, load owner, set gnt=1<<owner and hold_cnt=1.
  - If none: RELEASE goes to IDLE; IDLE stays in IDLE.
- Latency: a req sampled high at edge k in IDLE gives gnt high from edge k onward (one cycle after req is presented).
- GNT, evaluated at each edge:
  - req[owner]=0: go to RELEASE, preempt=0.
  - Else if hold_cnt==MAX_HOLD and (req & ~gnt)!=0: go to RELEASE, preempt=1.
  - Else stay in GNT; hold_cnt=min(hold_cnt+1, MAX_HOLD).
  - With no competitors, the owner keeps the grant indefinitely (hold_cnt saturates).
- RELEASE:
  - Lasts exactly one cycle: gnt=0, gnt_valid=0, preempt as set on entry.
  - Entry sets ptr=(owner+1) mod NREQ, wrapping NREQ-1 to 0.
  - The preempted owner is lowest priority in the next arbitration.
- No two owners are ever granted in consecutive cycles; there is always a ≥1-cycle gap.
- preempt is high only during a RELEASE entered by preemption; otherwise 0.
- hold_cnt width is clog2(MAX_HOLD)+1 and never wraps.
- req bits dropping in IDLE or RELEASE before sampling are simply not granted. No request latching or queuing.
- An unknown or illegal state encoding recovers to IDLE on the next edge with gnt=0.

Test Plan:
1. Async reset mid-grant: gnt=0010, pull reset=0 between edges -> gnt=0000, gnt_valid=0 immediately. Release reset with req=0000 -> stays IDLE, ptr=0.
2. Single requester, req=0001 held 12 cycles -> gnt=0001 for all 12 cycles after the first edge, preempt never asserts. Drop req -> one RELEASE cycle (gnt=0), then IDLE.
3. Simultaneous requests from IDLE with ptr=0, req=0101; requester 0 drops after 2 grant cycles -> gnt=0001 ×2, gap 0000 ×1, then gnt=0100, gnt_id=2.
4. Preemption, MAX_HOLD=4, req=0011 held constantly -> gnt=0001 ×4, 0000 with preempt=1, 0010 ×4, 0000 with preempt=1, 0001 … Each grant is exactly 4 cycles.
5. Pointer wrap: owner 3 releases (ptr becomes 0), req=1001 -> next gnt=0001. Then owner 0 releases (ptr=1) with req=1001 -> gnt=1000.
6. Drop during gap: req=0011, owner 0 releases, req[1] falls in the RELEASE cycle -> no grant, state IDLE, gnt=0000.
